life_sequencer: RTL and testbench

- Sequencing controller for the 8x8 Game-of-Life next-generation datapath. The datapath is combinational, 64-bit grid in, 64-bit next grid out.
- Owns the generation register and feeds it to the datapath. Loads a seed, then advances generations either on single steps or free-running at a programmable rate.
- Halts automatically on extinction, still-life or a generation limit. Replaces the bare start/mux scheme at top level.

---
 rtl/life_sequencer.sv | 155 +++++++++++++++
 tb/tb_life_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// life_sequencer: generation register and sequencing control for an 8x8 Game-of-Life datapath
// Optional feature macro: LIFE_OSC2_DETECT_EN (period-2 oscillator detection and halt)
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   load/seed  - pulse; capture seed grid, restart at generation 0 in PAUSED
//   run        - level; free-run enable
//   step       - pulse; single advance while PAUSED
//   period     - free-run advance every period+1 cycles
//   max_gen    - generation limit, 0 = unlimited
//   dp_grid    - current grid to the combinational datapath
//   dp_next    - next grid from the datapath
//   grid       - current grid (same as dp_grid)
//   gen_count  - saturating generations since load
//   state      - IDLE=00, PAUSED=01, RUNNING=10, HALTED=11
//   gen_valid  - one-cycle pulse after each advance
//   extinct, stable, done, osc2 - sticky halt reasons, cleared by load or reset
module life_sequencer #(
    parameter int GRID_W = 64,
    parameter int DIV_W  = 24,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [GRID_W-1:0] seed,
    input  logic              run,
    input  logic              step,
    input  logic [DIV_W-1:0]  period,
    input  logic [GEN_W-1:0]  max_gen,
    output logic [GRID_W-1:0] dp_grid,
    input  logic [GRID_W-1:0] dp_next,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic [1:0]        state,
    output logic              gen_valid,
    output logic              extinct,
    output logic              stable,
    output logic              done,
    output logic              osc2
);
    typedef enum logic [1:0] {IDLE = 2'b00, PAUSED = 2'b01, RUNNING = 2'b10, HALTED = 2'b11} state_t;

    state_t            state_q, state_d;
    logic [GRID_W-1:0] grid_q, grid_d;
    logic [GEN_W-1:0]  gen_q, gen_d, gen_inc;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              gen_valid_q, gen_valid_d;
    logic              extinct_q, extinct_d;
    logic              stable_q, stable_d;
    logic              done_q, done_d;
    logic              osc2_q, osc2_d;
    logic              adv, hit_ext, hit_stb, hit_done, hit_osc;

    assign gen_inc  = gen_q + GEN_W'(1);
    assign hit_ext  = dp_next == '0;
    assign hit_stb  = dp_next == grid_q;
    // gen_inc wraps to 0 only when saturated, which never matches a non-zero limit
    assign hit_done = max_gen != '0 && gen_inc == max_gen;

`ifdef LIFE_OSC2_DETECT_EN
    logic [GRID_W-1:0] prev_q, prev_d;
    // prev_q only holds a real grid once at least one advance has happened
    assign hit_osc = gen_q != '0 && dp_next == prev_q;
    always_comb prev_d = load ? '0 : adv ? grid_q : prev_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) prev_q <= '0;
        else        prev_q <= prev_d;
`else
    assign hit_osc = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        div_d     = div_q;
        extinct_d = extinct_q;
        stable_d  = stable_q;
        done_d    = done_q;
        osc2_d    = osc2_q;
        adv       = 1'b0;
        if (load) begin
            state_d   = PAUSED;
            grid_d    = seed;
            gen_d     = '0;
            div_d     = '0;
            extinct_d = seed == '0;
            stable_d  = 1'b0;
            done_d    = 1'b0;
            osc2_d    = 1'b0;
        end else begin
            case (state_q)
                PAUSED: begin
                    if (run) begin
                        state_d = RUNNING;
                        div_d   = '0;
                    end else adv = step;
                end
                RUNNING: begin
                    // dropping run wins over a coinciding tick; a shrunk period lets div_q wrap naturally
                    if (!run) state_d = PAUSED;
                    else if (div_q == period) adv = 1'b1;
                    else div_d = div_q + DIV_W'(1);
                end
                default: ;
            endcase
            if (adv) begin
                grid_d    = dp_next;
                gen_d     = &gen_q ? gen_q : gen_inc;
                div_d     = '0;
                extinct_d = extinct_q | hit_ext;
                stable_d  = stable_q | hit_stb;
                done_d    = done_q | hit_done;
                osc2_d    = osc2_q | hit_osc;
                if (hit_ext || hit_stb || hit_done || hit_osc) state_d = HALTED;
            end
        end
        gen_valid_d = adv;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grid_q      <= '0;
            gen_q       <= '0;
            div_q       <= '0;
            gen_valid_q <= 1'b0;
            extinct_q   <= 1'b0;
            stable_q    <= 1'b0;
            done_q      <= 1'b0;
            osc2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            gen_q       <= gen_d;
            div_q       <= div_d;
            gen_valid_q <= gen_valid_d;
            extinct_q   <= extinct_d;
            stable_q    <= stable_d;
            done_q      <= done_d;
            osc2_q      <= osc2_d;
        end
    end

    assign dp_grid   = grid_q;
    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign state     = state_q;
    assign gen_valid = gen_valid_q;
    assign extinct   = extinct_q;
    assign stable    = stable_q;
    assign done      = done_q;
    assign osc2      = osc2_q;
endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: directed checks of life_sequencer with a Game-of-Life datapath model
module tb_life_sequencer;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;

    logic        clk, reset, load, run, step;
    logic [63:0] seed, dp_grid, dp_next, grid;
    logic [23:0] period;
    logic [15:0] max_gen, gen_count;
    logic [1:0]  state;
    logic        gen_valid, extinct, stable, done, osc2;
    int          n_chk, n_pass;

    life_sequencer dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .period(period), .max_gen(max_gen), .dp_grid(dp_grid), .dp_next(dp_next),
        .grid(grid), .gen_count(gen_count), .state(state), .gen_valid(gen_valid),
        .extinct(extinct), .stable(stable), .done(done), .osc2(osc2)
    );

    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] nx;
        int n, rr, cc;
        nx = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && g[rr*8+cc]) n++;
                    end
                nx[r*8+c] = (n == 3) || (g[r*8+c] && n == 2);
            end
        return nx;
    endfunction

    always_comb dp_next = life(dp_grid);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b0; load = 1'b0; run = 1'b0; step = 1'b0;
        seed = '0; period = '0; max_gen = '0;
        #12;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_grid", grid, 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_flags", {59'd0, gen_valid, extinct, stable, done, osc2}, 64'd0);
        reset = 1'b1;
        run = 1'b1; step = 1'b1;
        tick(); tick(); tick();
        chk("idle_ignores_run", 64'(state), 64'd0);
        chk("idle_gen", 64'(gen_count), 64'd0);
        run = 1'b0; step = 1'b0;

        // single cell dies: extinction halt
        seed = SINGLE; load = 1'b1; tick(); load = 1'b0;
        chk("load_state", 64'(state), 64'd1);
        chk("load_grid", grid, SINGLE);
        chk("load_extinct", 64'(extinct), 64'd0);
        step = 1'b1; tick(); step = 1'b0;
        chk("ext_grid", grid, 64'd0);
        chk("ext_gen", 64'(gen_count), 64'd1);
        chk("ext_flag", 64'(extinct), 64'd1);
        chk("ext_state", 64'(state), 64'd3);
        chk("ext_gv_pulse", 64'(gen_valid), 64'd1);
        tick();
        chk("ext_gv_low", 64'(gen_valid), 64'd0);
        step = 1'b1; run = 1'b1; tick(); tick(); step = 1'b0; run = 1'b0;
        chk("halt_hold_gen", 64'(gen_count), 64'd1);
        chk("halt_hold_state", 64'(state), 64'd3);

        // block is a still life
        seed = BLOCK; load = 1'b1; tick(); load = 1'b0;
        chk("blk_load_ext", 64'(extinct), 64'd0);
        run = 1'b1; period = 24'd0; tick();
        chk("blk_running", 64'(state), 64'd2);
        tick();
        chk("blk_stable", 64'(stable), 64'd1);
        chk("blk_gen", 64'(gen_count), 64'd1);
        chk("blk_state", 64'(state), 64'd3);
        chk("blk_grid", grid, BLOCK);

        // blinker with period 3 and generation limit 5
        run = 1'b0; seed = BLINK_H; period = 24'd3; max_gen = 16'd5;
        load = 1'b1; tick(); load = 1'b0;
        chk("bl_stable_clr", 64'(stable), 64'd0);
        run = 1'b1; tick();
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk($sformatf("bl_gv_k%0d_i%0d", k, i), 64'(gen_valid), 64'(i == 3));
            end
            chk($sformatf("bl_gen_k%0d", k), 64'(gen_count), 64'(k));
        end
        chk("bl_done", 64'(done), 64'd1);
        chk("bl_state", 64'(state), 64'd3);
        chk("bl_grid", grid, BLINK_V);
        chk("bl_osc2", 64'(osc2), 64'd0);
        tick();
        chk("bl_gv_after", 64'(gen_valid), 64'd0);

        // load beats step; dropping run beats a tick
        run = 1'b0; max_gen = 16'd0; period = 24'd0;
        load = 1'b1; tick(); load = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        chk("stp_grid", grid, BLINK_V);
        chk("stp_gen", 64'(gen_count), 64'd1);
        load = 1'b1; step = 1'b1; tick(); load = 1'b0; step = 1'b0;
        chk("ldstp_grid", grid, BLINK_H);
        chk("ldstp_gen", 64'(gen_count), 64'd0);
        chk("ldstp_gv", 64'(gen_valid), 64'd0);
        chk("ldstp_state", 64'(state), 64'd1);
        run = 1'b1; tick();
        chk("pr_gen0", 64'(gen_count), 64'd0);
        tick();
        chk("pr_gen1", 64'(gen_count), 64'd1);
        run = 1'b0; tick();
        chk("pause_state", 64'(state), 64'd1);
        chk("pause_gen", 64'(gen_count), 64'd1);
        chk("pause_grid", grid, BLINK_V);
        chk("pause_gv", 64'(gen_valid), 64'd0);

        // free-run past generation counter saturation
        run = 1'b1; tick();
        repeat (65537) @(posedge clk);
        #1;
        chk("sat_gen", 64'(gen_count), 64'hFFFF);
        chk("sat_state", 64'(state), 64'd2);
        chk("sat_grid", grid, BLINK_H);
        tick();
        chk("sat_grid_next", grid, BLINK_V);
        chk("sat_gen_hold", 64'(gen_count), 64'hFFFF);
        chk("sat_gv", 64'(gen_valid), 64'd1);

        // asynchronous reset mid-run
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_grid", grid, 64'd0);
        chk("arst_gen", 64'(gen_count), 64'd0);
        chk("arst_flags", {59'd0, gen_valid, extinct, stable, done, osc2}, 64'd0);
        #3 reset = 1'b1;
        tick(); tick();
        chk("arst_idle", 64'(state), 64'd0);
        chk("arst_idle_grid", grid, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
